// File: rtl/ssc_pkg.sv
// Shared types and constants for the SSC fetch, decode and execute stages.
package ssc_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALT
    } fetch_state_e;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_F0     = 3'd1;
    localparam logic [2:0] COND_F1     = 3'd2;
    localparam logic [2:0] COND_F2     = 3'd3;
    localparam logic [2:0] COND_F3     = 3'd4;

endpackage

// File: rtl/ssc_branch_cond.sv
// Combinational branch-taken evaluation: flag select plus optional inversion.
module ssc_branch_cond
    import ssc_pkg::*;
(
    input  logic       i_valid,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    logic w_sel_result;

    always_comb begin
        w_sel_result = 1'b0;
        case (i_cond[2:0])
            COND_ALWAYS: w_sel_result = 1'b1;
            COND_F0:     w_sel_result = i_flags[0];
            COND_F1:     w_sel_result = i_flags[1];
            COND_F2:     w_sel_result = i_flags[2];
            COND_F3:     w_sel_result = i_flags[3];
            default:     w_sel_result = 1'b0;
        endcase
        o_taken = i_valid & (w_sel_result ^ i_cond[3]);
    end

endmodule

// File: rtl/ssc_fetch_unit.sv
// Instruction fetch / PC stage feeding the SSC decoder and register bank.
// Optional ack watchdog enabled by defining SSC_FETCH_TIMEOUT_EN.
module ssc_fetch_unit
    import ssc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    input  logic [31:0] br_target,
    input  logic [3:0]  flags,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault
);

    localparam logic [XLEN-1:0] LP_RESET_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [XLEN-1:0] LP_ALIGN    = ~32'd3;

    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 1..255");
    end

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic [XLEN-1:0] r_pc_out, w_pc_out_nxt;
    logic            r_req, w_req_nxt;
    logic            w_ack, w_accept, w_taken;

`ifdef SSC_FETCH_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT = TIMEOUT_CYC[7:0];
    logic [7:0] r_wd_cnt, w_wd_cnt_nxt, w_wd_cnt_inc;
    logic       r_fault, w_fault_nxt;
    assign w_wd_cnt_inc = r_wd_cnt + 8'd1;
`endif

    // An ack only completes a fetch once the request is actually on the bus.
    assign w_ack    = r_req & imem_ack;
    assign w_accept = (r_state == ISSUE) & instr_ready;

    ssc_branch_cond u_branch_cond (
        .i_valid (br_valid),
        .i_cond  (br_cond),
        .i_flags (flags),
        .o_taken (w_taken)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        w_req_nxt    = r_req;
`ifdef SSC_FETCH_TIMEOUT_EN
        w_wd_cnt_nxt = r_wd_cnt;
        w_fault_nxt  = r_fault;
`endif
        case (r_state)
            FETCH: begin
                w_req_nxt = 1'b1;
                if (w_ack) begin
                    w_instr_nxt  = imem_rdata;
                    w_pc_out_nxt = r_pc;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = ISSUE;
                end
`ifdef SSC_FETCH_TIMEOUT_EN
                else if (w_wd_cnt_inc == LP_TIMEOUT) begin
                    w_wd_cnt_nxt = w_wd_cnt_inc;
                    w_fault_nxt  = 1'b1;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = HALT;
                end else begin
                    w_wd_cnt_nxt = w_wd_cnt_inc;
                end
`endif
            end
            ISSUE: begin
                if (w_accept) begin
                    if (halt_req) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt    = w_taken ? (br_target & LP_ALIGN)
                                              : (r_pc + 32'(PC_STEP));
                        w_req_nxt   = 1'b1;
                        w_state_nxt = FETCH;
`ifdef SSC_FETCH_TIMEOUT_EN
                        w_wd_cnt_nxt = 8'd0;
`endif
                    end
                end
            end
            HALT: begin
                w_req_nxt = 1'b0;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= LP_RESET_PC;
            r_instr  <= '0;
            r_pc_out <= LP_RESET_PC;
            r_req    <= 1'b0;
        end else if (clk_en) begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_req    <= w_req_nxt;
        end
    end

`ifdef SSC_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= 8'd0;
            r_fault  <= 1'b0;
        end else if (clk_en) begin
            r_wd_cnt <= w_wd_cnt_nxt;
            r_fault  <= w_fault_nxt;
        end
    end
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_pc & LP_ALIGN;
    assign instr_valid = (r_state == ISSUE);
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign halted      = (r_state == HALT);

endmodule

// File: doc/ssc_fetch_unit.md
Name: ssc_fetch_unit

Overview:
Instruction-fetch and program-counter stage directly upstream of the SSC register bank and decoder. Holds the architectural PC and fetches instruction words over a req/ack memory port. It presents each word to the decoder with a valid/ready handshake and drives the register bank's PC input. Branch redirection is resolved here from the decoder's branch request and the bank's condition flags.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment for sequential fetch
TIMEOUT_CYC, 255, memory-ack watchdog limit (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; low freezes all state and outputs
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address (= pc, bits[1:0] always 0)
imem_ack  in  1  memory response strobe, one cycle
imem_rdata  in  32  instruction word, valid with imem_ack
instr_valid  out  1  instr holds an unconsumed word
instr_ready  in  1  decoder accepts instr this cycle
instr  out  32  fetched instruction word
pc_out  out  32  address of the word on instr; feeds register bank PC input
br_valid  in  1  decoder: issued instruction is a branch (sampled only on accept)
br_cond  in  4  [3]=invert, [2:0]=flag select
br_target  in  32  branch destination
flags  in  4  condition flags from register bank
halt_req  in  1  decoder: issued instruction is HALT (sampled on accept)
halted  out  1  fetch stopped
fault  out  1  watchdog expiry (tied 0 without optional feature)

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0, instr=0, pc_out=RESET_PC, halted=0, fault=0. imem_req first asserts on the first enabled edge after reset release.
- All register updates are qualified by clk_en. Handshakes count only on cycles where clk_en=1.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, imem_req<=0, go ISSUE. Minimum latency from req to valid is 1 cycle after ack.
- ISSUE: instr_valid=1 and instr stable until accept (instr_valid & instr_ready). On accept:
  - halt_req=1 -> HALT. halt_req has priority over br_valid.
  - else taken branch -> pc<={br_target[31:2],2'b00}, go FETCH.
  - else pc<=pc+PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0), go FETCH.
  - On the accept edge instr_valid drops to 0; no new fetch overlaps the issue.
- Taken rule: sel=br_cond[2:0]. sel 0 = always; 1..4 = flags[0..3]; 5..7 = never. taken = br_valid & (sel_result XOR br_cond[3]).
- HALT: halted=1, imem_req=0, instr_valid=0. Exit only via reset.
- imem_ack outside FETCH is ignored.
- br_valid, br_cond, br_target, flags and halt_req are don't-care when no accept occurs.

Optional Feature:
SSC_FETCH_TIMEOUT_EN. When defined, an 8-bit counter clears on entry to FETCH and increments each enabled FETCH cycle without ack. When the count reaches TIMEOUT_CYC: fault=1 (sticky until reset), go HALT. When undefined, the counter is absent, fault is tied 0, and FETCH waits indefinitely.

Decomposition:
- Package ssc_pkg: fetch state enum (FETCH, ISSUE, HALT); condition-select constants COND_ALWAYS=0, COND_F0..COND_F3=1..4; XLEN=32.
- One sub-module: ssc_branch_cond (combinational taken evaluation), reused by later execute stages.

Test Plan:
- Reset then ack with 0x1111_0000 after 2 wait cycles -> instr_valid=1, instr=0x1111_0000, pc_out=0; next imem_addr=0x4 after accept.
- Hold instr_ready=0 for 5 cycles -> instr and pc_out stable, imem_req=0; accept -> next fetch at pc+4.
- Accept with br_valid=1, br_cond=4'b0001, flags=4'b0001, br_target=0x0000_0103 -> next imem_addr=0x0000_0100. Same with br_cond=4'b1001 -> sequential address.
- pc=0xFFFF_FFFC, sequential accept -> next imem_addr=0x0000_0000.
- Accept with halt_req=1 and br_valid=1 -> halted=1, imem_req stays 0. Assert rst_n=0 mid-FETCH -> all outputs at reset values immediately.
- clk_en=0 for 3 cycles with imem_ack pulsed -> no state change. With SSC_FETCH_TIMEOUT_EN and no ack for 255 cycles -> fault=1, halted=1.
